ex_hazard_ctrl: RTL and testbench

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall, branch flush
// and the freeze of the back end while a multi-cycle ALU op occupies EX.
module ex_hazard_ctrl #(
    parameter int MC_LATENCY = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1Used,
    input  logic       id_rs2Used,
    input  logic [4:0] id_rd,
    input  logic       id_regWrite,
    input  logic       id_memRead,
    input  logic       id_multiCycle,
    input  logic       pcSel,
    output logic [1:0] forwardA,
    output logic [1:0] forwardB,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       pipe_hold,
    output logic       ex_busy
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1Used;
        logic       rs2Used;
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
        logic       mc;
    } entry_t;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [5:0] CNT_INIT = 6'(MC_LATENCY - 2);

    state_t     state, state_next;
    logic [5:0] cnt, cnt_next;
    entry_t     ex_e, mem_e, wb_e, id_e;
    logic       load_use;
    logic       fa0, fa1, fb0, fb1;
    logic       unused_fields;

    // A producer feeds the consumer in EX when it writes a nonzero register the consumer reads.
    function automatic logic fwd_hit(input entry_t prod, input logic cons_valid,
                                     input logic src_used, input logic [4:0] src);
        return cons_valid & src_used & prod.valid & prod.regWrite &
               (prod.rd != 5'd0) & (prod.rd == src);
    endfunction

    assign fa0 = fwd_hit(mem_e, ex_e.valid, ex_e.rs1Used, ex_e.rs1);
    assign fa1 = fwd_hit(wb_e,  ex_e.valid, ex_e.rs1Used, ex_e.rs1);
    assign fb0 = fwd_hit(mem_e, ex_e.valid, ex_e.rs2Used, ex_e.rs2);
    assign fb1 = fwd_hit(wb_e,  ex_e.valid, ex_e.rs2Used, ex_e.rs2);

    assign forwardA = {fa1 & ~fa0, fa0};
    assign forwardB = {fb1 & ~fb0, fb0};

    assign load_use = id_valid & ex_e.valid & ex_e.memRead & (ex_e.rd != 5'd0) &
                      ((id_rs1Used & (id_rs1 == ex_e.rd)) | (id_rs2Used & (id_rs2 == ex_e.rd)));

    always_comb begin
        id_e.valid    = id_valid & ~flush_idex;
        id_e.rs1      = id_rs1;
        id_e.rs2      = id_rs2;
        id_e.rs1Used  = id_rs1Used;
        id_e.rs2Used  = id_rs2Used;
        id_e.rd       = id_rd;
        id_e.regWrite = id_regWrite;
        id_e.memRead  = id_memRead;
        id_e.mc       = id_multiCycle;
    end

    // A multi-cycle op entering EX wins over a branch and a load-use stall; the branch
    // flush is masked during reset so every output reads zero while rst is high.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        pipe_hold  = 1'b0;
        ex_busy    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_e.valid && ex_e.mc) begin
                    pipe_hold  = 1'b1;
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    ex_busy    = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                end else if (pcSel && !rst) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            BUSY: begin
                ex_busy = 1'b1;
                if (cnt != 6'd0) begin
                    pipe_hold = 1'b1;
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    cnt_next  = cnt - 6'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_e  <= '0;
            mem_e <= '0;
            wb_e  <= '0;
        end else if (!pipe_hold) begin
            wb_e  <= mem_e;
            mem_e <= ex_e;
            ex_e  <= id_e;
        end
    end

    assign unused_fields = ^{ex_e.regWrite,
                             mem_e.rs1, mem_e.rs2, mem_e.rs1Used, mem_e.rs2Used, mem_e.memRead, mem_e.mc,
                             wb_e.rs1, wb_e.rs2, wb_e.rs1Used, wb_e.rs2Used, wb_e.memRead, wb_e.mc};

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams, all compared against an instruction-level pipeline model.
module tb_ex_hazard_ctrl;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1Used, id_rs2Used, id_regWrite, id_memRead, id_multiCycle, pcSel;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] forwardA, forwardB;
    logic       stall_if, stall_id, flush_ifid, flush_idex, pipe_hold, ex_busy;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MC_LATENCY(MC)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1Used(id_rs1Used), .id_rs2Used(id_rs2Used),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_multiCycle(id_multiCycle), .pcSel(pcSel),
        .forwardA(forwardA), .forwardB(forwardB),
        .stall_if(stall_if), .stall_id(stall_id),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .pipe_hold(pipe_hold), .ex_busy(ex_busy)
    );

    typedef struct {
        bit valid;
        int rs1, rs2;
        bit u1, u2;
        int rd;
        bit rw, mr, mc;
    } instr_t;

    // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB; age counts cycles the EX op has been held.
    instr_t pipe[3];
    int     age;
    int     checks = 0;
    int     failures = 0;
    bit     eStallIf, eStallId, eFlushIfid, eFlushIdex, eHold, eBusy;
    logic [1:0] eFwdA, eFwdB;

    task automatic expectVal(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic setId(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit rw, input bit mr, input bit mc, input bit br);
        id_valid      = v;
        id_rs1        = 5'(rs1);
        id_rs2        = 5'(rs2);
        id_rs1Used    = u1;
        id_rs2Used    = u2;
        id_rd         = 5'(rd);
        id_regWrite   = rw;
        id_memRead    = mr;
        id_multiCycle = mc;
        pcSel         = br;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        age = 0;
    endtask

    function automatic logic [1:0] fwdSel(input bit second);
        int src;
        bit used;
        src  = second ? pipe[0].rs2 : pipe[0].rs1;
        used = second ? pipe[0].u2 : pipe[0].u1;
        if (!(pipe[0].valid && used)) return 2'b00;
        if (pipe[1].valid && pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == src) return 2'b01;
        if (pipe[2].valid && pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic computeModel();
        bit mcActive, loadUse;
        mcActive = pipe[0].valid && pipe[0].mc;
        loadUse  = id_valid && pipe[0].valid && pipe[0].mr && pipe[0].rd != 0 &&
                   ((id_rs1Used && int'(id_rs1) == pipe[0].rd) || (id_rs2Used && int'(id_rs2) == pipe[0].rd));
        {eStallIf, eStallId, eFlushIfid, eFlushIdex, eHold, eBusy} = '0;
        if (mcActive) begin
            eBusy    = 1'b1;
            eHold    = (age < MC - 1);
            eStallIf = eHold;
            eStallId = eHold;
        end else if (pcSel) begin
            eFlushIfid = 1'b1;
            eFlushIdex = 1'b1;
        end else if (loadUse) begin
            eStallIf   = 1'b1;
            eStallId   = 1'b1;
            eFlushIdex = 1'b1;
        end
        eFwdA = fwdSel(1'b0);
        eFwdB = fwdSel(1'b1);
    endtask

    task automatic checkOutput();
        @(negedge clk);
        computeModel();
        expectVal("forwardA", forwardA, eFwdA);
        expectVal("forwardB", forwardB, eFwdB);
        expectVal("stall_if", {1'b0, stall_if}, {1'b0, eStallIf});
        expectVal("stall_id", {1'b0, stall_id}, {1'b0, eStallId});
        expectVal("flush_ifid", {1'b0, flush_ifid}, {1'b0, eFlushIfid});
        expectVal("flush_idex", {1'b0, flush_idex}, {1'b0, eFlushIdex});
        expectVal("pipe_hold", {1'b0, pipe_hold}, {1'b0, eHold});
        expectVal("ex_busy", {1'b0, ex_busy}, {1'b0, eBusy});
    endtask

    task automatic clockEdge();
        @(posedge clk);
        if (!eHold) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{valid: id_valid && !eFlushIdex, rs1: int'(id_rs1), rs2: int'(id_rs2),
                        u1: id_rs1Used, u2: id_rs2Used, rd: int'(id_rd),
                        rw: id_regWrite, mr: id_memRead, mc: id_multiCycle};
            age = 0;
        end else begin
            age++;
        end
        #1;
    endtask

    task automatic applyStimulus();
        checkOutput();
        clockEdge();
    endtask

    task automatic checkAllZero(input string tag);
        expectVal({tag, "_fwdA"}, forwardA, 2'b00);
        expectVal({tag, "_fwdB"}, forwardB, 2'b00);
        expectVal({tag, "_ctrl"}, {1'b0, |{stall_if, stall_id, flush_ifid, flush_idex, pipe_hold, ex_busy}}, 2'b00);
    endtask

    task automatic nop();
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        setId(1, 3, 3, 1, 1, 3, 1, 0, 0, 1);
        #2;
        checkAllZero("reset");
        nop();
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        #1;

        // Producer in MEM, then in WB, feeding an rs1 consumer.
        setId(1, 1, 2, 1, 1, 5, 1, 0, 0, 0); applyStimulus();
        setId(1, 5, 2, 1, 1, 6, 1, 0, 0, 0); applyStimulus();
        nop(); checkOutput(); expectVal("fwdA_exmem", forwardA, 2'b01); clockEdge();
        setId(1, 1, 2, 1, 1, 5, 1, 0, 0, 0); applyStimulus();
        nop(); applyStimulus();
        setId(1, 5, 0, 1, 0, 8, 1, 0, 0, 0); applyStimulus();
        nop(); checkOutput(); expectVal("fwdA_memwb", forwardA, 2'b10); clockEdge();

        // Two producers of x5: the younger one (MEM) wins.
        setId(1, 1, 1, 1, 1, 5, 1, 0, 0, 0); applyStimulus();
        setId(1, 2, 2, 1, 1, 5, 1, 0, 0, 0); applyStimulus();
        setId(1, 0, 5, 0, 1, 9, 1, 0, 0, 0); applyStimulus();
        nop(); checkOutput(); expectVal("fwdB_priority", forwardB, 2'b01); clockEdge();

        // Load-use on rs2: one bubble, then forward from WB.
        setId(1, 1, 1, 1, 0, 7, 1, 1, 0, 0); applyStimulus();
        setId(1, 0, 7, 0, 1, 9, 1, 0, 0, 0); checkOutput();
        expectVal("lu_stall", {stall_if, stall_id}, 2'b11);
        expectVal("lu_flush_idex", {1'b0, flush_idex}, 2'b01);
        clockEdge();
        checkOutput(); expectVal("lu_release", {stall_if, flush_idex}, 2'b00); clockEdge();
        nop(); checkOutput(); expectVal("lu_fwdB", forwardB, 2'b10); clockEdge();

        // Branch coinciding with a load-use hazard.
        setId(1, 1, 1, 1, 0, 7, 1, 1, 0, 0); applyStimulus();
        setId(1, 0, 7, 0, 1, 9, 1, 0, 0, 1); checkOutput();
        expectVal("br_flush", {flush_ifid, flush_idex}, 2'b11);
        expectVal("br_nostall", {stall_if, stall_id}, 2'b00);
        clockEdge();

        // x0 producer never forwards nor stalls.
        setId(1, 1, 1, 1, 0, 0, 1, 1, 0, 0); applyStimulus();
        setId(1, 0, 0, 1, 0, 4, 1, 0, 0, 0); checkOutput();
        expectVal("x0_nostall", {stall_if, stall_id}, 2'b00); clockEdge();
        nop(); checkOutput(); expectVal("x0_fwdA", forwardA, 2'b00); clockEdge();

        // Multi-cycle op: hold for MC-1 cycles, busy for MC.
        setId(1, 1, 2, 1, 1, 9, 1, 0, 1, 0); applyStimulus();
        setId(1, 9, 0, 1, 0, 10, 1, 0, 0, 1);
        for (int c = 0; c < MC; c++) begin
            checkOutput();
            expectVal("mc_busy", {1'b0, ex_busy}, 2'b01);
            expectVal("mc_hold", {1'b0, pipe_hold}, (c < MC - 1) ? 2'b01 : 2'b00);
            expectVal("mc_noflush", {flush_ifid, flush_idex}, 2'b00);
            clockEdge();
            pcSel = 1'b0;
        end
        nop(); checkOutput(); expectVal("mc_done", {1'b0, ex_busy}, 2'b00); clockEdge();

        // Reset in the middle of a multi-cycle op.
        setId(1, 1, 2, 1, 1, 9, 1, 0, 1, 0); applyStimulus();
        setId(1, 9, 9, 1, 1, 3, 1, 0, 0, 0); applyStimulus();
        checkOutput();
        pcSel = 1'b1;
        rst = 1'b1;
        #1;
        checkAllZero("midbusy_reset");
        @(posedge clk); #1;
        checkAllZero("reset_held");
        @(negedge clk);
        rst = 1'b0;
        pcSel = 1'b0;
        clearModel();
        #1;

        // Random instruction stream over a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            bit atStart;
            atStart = pipe[0].valid && pipe[0].mc && age == 0;
            setId(($urandom % 4) != 0, $urandom % 4, $urandom % 4, $urandom % 2, $urandom % 2,
                  $urandom % 4, $urandom % 2, ($urandom % 3) == 0, ($urandom % 10) == 0,
                  (($urandom % 6) == 0) && !atStart);
            applyStimulus();
        end

        $display("[TB] stimulus complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
